max_q_scanner: RTL and testbench



---
 rtl/max_q_scanner_if.sv | 26 ++
 rtl/max_q_scanner.sv | 67 ++++++
 tb/tb_max_q_scanner.sv | 121 ++++++++++++
 3 files changed

// File: rtl/max_q_scanner_if.sv
// max_q_scanner_if: scan request, Q-table read port and max-Q result bundle.
interface max_q_scanner_if #(
    parameter int STATE_W = 4,
    parameter int ACT_W   = 2,
    parameter int Q_W     = 16
);
    logic                     start;
    logic [STATE_W-1:0]       next_state;
    logic                     q_rd_en;
    logic [STATE_W+ACT_W-1:0] q_addr;
    logic [Q_W-1:0]           q_rd_data;
    logic [Q_W-1:0]           max_q;
    logic [ACT_W-1:0]         best_action;
    logic                     busy;
    logic                     done;

    modport slave (
        input  start, next_state, q_rd_data,
        output q_rd_en, q_addr, max_q, best_action, busy, done
    );

    modport master (
        output start, next_state, q_rd_data,
        input  q_rd_en, q_addr, max_q, best_action, busy, done
    );
endinterface

// File: rtl/max_q_scanner.sv
// max_q_scanner: reads one Q-table row and reports the signed maximum and its action index.
module max_q_scanner #(
    parameter int NUM_ACTIONS = 4,
    parameter int STATE_W     = 4,
    parameter int ACT_W       = 2,
    parameter int Q_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    max_q_scanner_if.slave   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [ACT_W-1:0] LAST = ACT_W'(NUM_ACTIONS - 1);

    logic [1:0]         state_q, state_d;
    logic [ACT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] st_q, st_d;
    logic               vld_q;
    logic [ACT_W-1:0]   idx_q;
    logic [Q_W-1:0]     max_q_q, max_q_d;
    logic [ACT_W-1:0]   best_q, best_d;
    logic               fetch, load;

    assign fetch = state_q == FETCH;
    // Read data trails the strobe by one cycle; action 0 seeds the max unconditionally.
    assign load  = vld_q && (idx_q == '0 || $signed(bus.q_rd_data) > $signed(max_q_q));

    always_comb begin
        state_d = state_q == IDLE  ? (bus.start ? FETCH : IDLE) :
                  state_q == FETCH ? (cnt_q == LAST ? WAIT : FETCH) :
                  state_q == WAIT  ? DONE : IDLE;
        st_d    = state_q == IDLE && bus.start ? bus.next_state : st_q;
        cnt_d   = fetch && cnt_q != LAST ? cnt_q + ACT_W'(1) : '0;
        max_q_d = load ? bus.q_rd_data : max_q_q;
        best_d  = load ? idx_q : best_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            max_q_q <= '0;
            best_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            vld_q   <= fetch;
            idx_q   <= cnt_q;
            max_q_q <= max_q_d;
            best_q  <= best_d;
        end
    end

    assign bus.q_rd_en     = fetch;
    assign bus.q_addr      = fetch ? {st_q, cnt_q} : '0;
    assign bus.max_q       = max_q_q;
    assign bus.best_action = best_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.done        = state_q == DONE;
endmodule

// File: tb/tb_max_q_scanner.sv
// tb_max_q_scanner: directed row scans against a one-cycle-latency Q-table model.
module tb_max_q_scanner;
    logic clk, rst_n;
    int n_chk, n_err, n_done;
    logic [15:0] row [4];

    max_q_scanner_if #(.STATE_W(4), .ACT_W(2), .Q_W(16)) bus ();

    max_q_scanner #(.NUM_ACTIONS(4), .STATE_W(4), .ACT_W(2), .Q_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Garbage outside valid reads catches sampling on the wrong cycle.
    always @(posedge clk) bus.q_rd_data <= bus.q_rd_en ? row[bus.q_addr[1:0]] : 16'hDEAD;
    always @(posedge clk) if (bus.done) n_done++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic scan(input logic [3:0] s, input logic [15:0] r0, r1, r2, r3,
                        input logic [15:0] emax, input logic [1:0] ebest, input bit glitch);
        int d0;
        row[0] = r0; row[1] = r1; row[2] = r2; row[3] = r3;
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.next_state = s;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.start = glitch && k == 1;
            if (glitch && k == 1) bus.next_state = ~s;
            chk("rd_en", bus.q_rd_en, 1'b1);
            chk("addr", bus.q_addr, {s, 2'(k)});
            chk("busy", bus.busy, 1'b1);
            chk("done_f", bus.done, 1'b0);
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk("wait_rd_en", bus.q_rd_en, 1'b0);
        chk("wait_addr", bus.q_addr, 6'h0);
        chk("wait_busy", bus.busy, 1'b1);
        chk("wait_done", bus.done, 1'b0);
        @(negedge clk);
        chk("done", bus.done, 1'b1);
        chk("done_busy", bus.busy, 1'b1);
        chk("max_q", bus.max_q, emax);
        chk("best", bus.best_action, ebest);
        if (glitch) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("idle_done", bus.done, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_rd_en", bus.q_rd_en, 1'b0);
        @(negedge clk);
        chk("still_idle", bus.busy, 1'b0);
        chk("hold_max", bus.max_q, emax);
        chk("hold_best", bus.best_action, ebest);
        chk("done_count", 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        n_chk = 0; n_err = 0; n_done = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.next_state = '0;
        for (int i = 0; i < 4; i++) row[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_rd_en", bus.q_rd_en, 1'b0);
        chk("rst_addr", bus.q_addr, 6'h0);
        chk("rst_max", bus.max_q, 16'h0);
        chk("rst_best", bus.best_action, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        scan(4'd5, 16'h0100, 16'h0700, 16'h0200, 16'hFF00, 16'h0700, 2'd1, 1'b0);
        scan(4'd2, 16'hFE00, 16'hFF80, 16'hFD00, 16'hFF80, 16'hFF80, 2'd1, 1'b0);
        scan(4'd9, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 2'd0, 1'b0);
        scan(4'd7, 16'h8000, 16'h0000, 16'h0001, 16'h7FFF, 16'h7FFF, 2'd3, 1'b0);
        scan(4'hA, 16'h0050, 16'h0010, 16'h0060, 16'h0060, 16'h0060, 2'd2, 1'b1);

        row[0] = 16'h0900; row[1] = 16'h0100; row[2] = 16'h0100; row[3] = 16'h0100;
        n_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.next_state = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_addr", bus.q_addr, {4'd3, 2'd2});
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_en", bus.q_rd_en, 1'b0);
        chk("arst_addr", bus.q_addr, 6'h0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_max", bus.max_q, 16'h0);
        chk("arst_best", bus.best_action, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_idle", bus.busy, 1'b0);
        chk("abort_rd_en", bus.q_rd_en, 1'b0);

        scan(4'd3, 16'h0300, 16'h0100, 16'h0080, 16'h0200, 16'h0300, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
